// File: rtl/keyed_mux_bank.sv
// Bank of NUM_SITES keyed 4:1 selectors behind one serially loaded key register.
// Optional macro KEY_PARITY_EN appends an even-parity bit to the load and adds a FAULT state.
module keyed_mux_bank #(
    parameter int NUM_SITES = 5,
    parameter int W         = 1,
    localparam int KW       = 2 * NUM_SITES,
    localparam int CW       = $clog2(KW + 2)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SITES*4*W-1:0]  cand_i,
    input  logic                      key_bit_i,
    input  logic                      key_vld_i,
    output logic                      key_rdy_o,
    input  logic                      key_clr_i,
    output logic [NUM_SITES*W-1:0]    mux_o,
    output logic                      mux_vld_o,
    output logic                      key_loaded_o,
    output logic [CW-1:0]             key_cnt_o,
    output logic                      key_err_o
);

`ifdef KEY_PARITY_EN
    localparam int LOAD_LEN = KW + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, ARMED, FAULT} state_t;
`else
    localparam int LOAD_LEN = KW;
    typedef enum logic [1:0] {IDLE, SHIFT, ARMED} state_t;
`endif

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [KW-1:0]            r_key;
    logic [CW-1:0]            r_cnt;
    logic                     r_rdy;
    logic [NUM_SITES*W-1:0]   r_mux;
    logic [NUM_SITES*W-1:0]   w_mux_sel;
    logic                     r_mux_vld;
    logic                     w_accept;
    logic                     w_last;

    assign w_accept = key_vld_i && r_rdy && !key_clr_i;
    assign w_last   = w_accept && (r_cnt == CW'(LOAD_LEN - 1));

`ifdef KEY_PARITY_EN
    logic w_parity_ok;
    // Even parity: stored key bits plus the parity bit must XOR to zero.
    assign w_parity_ok = ~((^r_key) ^ key_bit_i);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (key_clr_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, SHIFT: begin
                    if (w_last) begin
`ifdef KEY_PARITY_EN
                        w_state_nxt = w_parity_ok ? ARMED : FAULT;
`else
                        w_state_nxt = ARMED;
`endif
                    end else if (w_accept) begin
                        w_state_nxt = SHIFT;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Site s index is {key[2s], key[2s+1]} with key[2s] as the MSB.
    always_comb begin
        w_mux_sel = '0;
        for (int unsigned s = 0; s < NUM_SITES; s++) begin
            logic [1:0] idx;
            idx = {r_key[2*s], r_key[2*s+1]};
            w_mux_sel[s*W +: W] = cand_i[(4*s + idx)*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key     <= '0;
            r_cnt     <= '0;
            r_rdy     <= 1'b0;
            r_mux     <= '0;
            r_mux_vld <= 1'b0;
        end else if (key_clr_i) begin
            r_key     <= '0;
            r_cnt     <= '0;
            r_rdy     <= 1'b1;
            r_mux     <= '0;
            r_mux_vld <= 1'b0;
        end else begin
            r_rdy <= (w_state_nxt == IDLE) || (w_state_nxt == SHIFT);
            if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
                // The parity bit (count == KW) is checked but never shifted in.
                if (r_cnt < CW'(KW)) begin
                    r_key <= {key_bit_i, r_key[KW-1:1]};
                end
            end
            r_mux     <= (r_state == ARMED) ? w_mux_sel : '0;
            r_mux_vld <= (r_state == ARMED);
        end
    end

    assign key_rdy_o    = r_rdy;
    assign key_cnt_o    = r_cnt;
    assign mux_o        = r_mux;
    assign mux_vld_o    = r_mux_vld;
    assign key_loaded_o = (r_state == ARMED);
`ifdef KEY_PARITY_EN
    assign key_err_o    = (r_state == FAULT);
`else
    assign key_err_o    = 1'b0;
`endif

endmodule
